// File: rtl/frame_ram_scheduler.sv
// -----------------------------------------------------------------------------
// frame_ram_scheduler
//   Shares the single write port of the ping-pong telemetry frame RAM between
//   two filler requesters using round-robin arbitration. It also owns page
//   selection: a finished-page pulse from the reader schedules a page swap,
//   and bufSwitch toggles on every swap.
//
// Ports
//   clk, reset (async, active-low)
//   req0/dat0/adr0 -> gnt0   requester 0 (req held until gnt pulse)
//   req1/dat1/adr1 -> gnt1   requester 1
//   rdFrameDone              reader finished its page (one-cycle pulse)
//   outWDAT/outWADR/outWREN  RAM write port, outWADR = {wrPage, adr}
//   bufSwitch, wrPage        page-swap level and current write page
//   ovr                      sticky overrun: extra rdFrameDone before swap
//   wrCnt [15:0]             only with WR_COUNT_EN: writes done on last page
//
// Optional feature: define WR_COUNT_EN to add the wrCnt output and the
// per-page write counter.
// -----------------------------------------------------------------------------
module frame_ram_scheduler #(
  parameter int DW   = 12,
  parameter int AW   = 10,
  parameter int HOLD = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] dat0,
  input  logic [AW-1:0] adr0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] dat1,
  input  logic [AW-1:0] adr1,
  output logic          gnt1,
  input  logic          rdFrameDone,
  output logic [DW-1:0] outWDAT,
  output logic [AW:0]   outWADR,
  output logic          outWREN,
  output logic          bufSwitch,
  output logic          wrPage,
`ifdef WR_COUNT_EN
  output logic [15:0]   wrCnt,
`endif
  output logic          ovr
);

  typedef enum logic [1:0] {S_IDLE, S_SWAP, S_WRITE, S_ACK} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rrPtr, w_rrPtr_nxt;
  logic          r_winner, w_winner_nxt;
  logic [2:0]    r_holdCnt, w_holdCnt_nxt;
  logic          r_swapPend, w_swapPend_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic          r_wrPage, w_wrPage_nxt;
  logic          r_bufSwitch, w_bufSwitch_nxt;
  logic [DW-1:0] r_outWDAT, w_outWDAT_nxt;
  logic [AW:0]   r_outWADR, w_outWADR_nxt;
  logic          r_outWREN, w_outWREN_nxt;
  logic          r_gnt0, w_gnt0_nxt;
  logic          r_gnt1, w_gnt1_nxt;
  logic          w_win;
  logic          w_swapClr;
  logic          w_wrDone;

  always_comb begin
    w_state_nxt     = r_state;
    w_rrPtr_nxt     = r_rrPtr;
    w_winner_nxt    = r_winner;
    w_holdCnt_nxt   = r_holdCnt;
    w_wrPage_nxt    = r_wrPage;
    w_bufSwitch_nxt = r_bufSwitch;
    w_outWDAT_nxt   = r_outWDAT;
    w_outWADR_nxt   = r_outWADR;
    w_outWREN_nxt   = r_outWREN;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_win           = 1'b0;
    w_wrDone        = 1'b0;
    w_swapClr       = (r_state == S_SWAP);

    // A new rdFrameDone always wins over the clear in the SWAP cycle.
    w_swapPend_nxt  = rdFrameDone ? 1'b1 : (w_swapClr ? 1'b0 : r_swapPend);
    w_ovr_nxt       = r_ovr | (rdFrameDone & r_swapPend & ~w_swapClr);

    case (r_state)
      S_IDLE: begin
        if (r_swapPend) begin
          w_state_nxt = S_SWAP;
        end else if (req0 || req1) begin
          // Pointer side wins if it is requesting, otherwise the other side.
          w_win         = (r_rrPtr ? req1 : req0) ? r_rrPtr : ~r_rrPtr;
          w_winner_nxt  = w_win;
          w_outWDAT_nxt = w_win ? dat1 : dat0;
          w_outWADR_nxt = {r_wrPage, (w_win ? adr1 : adr0)};
          w_outWREN_nxt = 1'b1;
          w_holdCnt_nxt = 3'd1;
          w_state_nxt   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_holdCnt == 3'(HOLD)) begin
          w_wrDone      = 1'b1;
          w_outWREN_nxt = 1'b0;
          w_gnt0_nxt    = ~r_winner;
          w_gnt1_nxt    = r_winner;
          w_rrPtr_nxt   = ~r_winner;
          w_state_nxt   = S_ACK;
        end else begin
          w_holdCnt_nxt = r_holdCnt + 3'd1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      S_SWAP: begin
        w_wrPage_nxt    = ~r_wrPage;
        w_bufSwitch_nxt = ~r_bufSwitch;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rrPtr     <= 1'b0;
      r_winner    <= 1'b0;
      r_holdCnt   <= 3'd0;
      r_swapPend  <= 1'b0;
      r_ovr       <= 1'b0;
      r_wrPage    <= 1'b0;
      r_bufSwitch <= 1'b0;
      r_outWDAT   <= '0;
      r_outWADR   <= '0;
      r_outWREN   <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rrPtr     <= w_rrPtr_nxt;
      r_winner    <= w_winner_nxt;
      r_holdCnt   <= w_holdCnt_nxt;
      r_swapPend  <= w_swapPend_nxt;
      r_ovr       <= w_ovr_nxt;
      r_wrPage    <= w_wrPage_nxt;
      r_bufSwitch <= w_bufSwitch_nxt;
      r_outWDAT   <= w_outWDAT_nxt;
      r_outWADR   <= w_outWADR_nxt;
      r_outWREN   <= w_outWREN_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
    end
  end

`ifdef WR_COUNT_EN
  logic [15:0] r_pageCnt;
  logic [15:0] r_wrCnt;

  // SWAP and a write completion are mutually exclusive states, so the
  // snapshot/clear never collides with an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pageCnt <= '0;
      r_wrCnt   <= '0;
    end else if (w_swapClr) begin
      r_wrCnt   <= r_pageCnt;
      r_pageCnt <= '0;
    end else if (w_wrDone && (r_pageCnt != 16'hFFFF)) begin
      r_pageCnt <= r_pageCnt + 16'd1;
    end
  end

  assign wrCnt = r_wrCnt;
`endif

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign outWDAT   = r_outWDAT;
  assign outWADR   = r_outWADR;
  assign outWREN   = r_outWREN;
  assign bufSwitch = r_bufSwitch;
  assign wrPage    = r_wrPage;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_frame_ram_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_ram_scheduler
//   Directed bench for frame_ram_scheduler with default parameters
//   (DW=12, AW=10, HOLD=2). Inputs change #1 after the rising edge and
//   outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_frame_ram_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [11:0] dat0 = '0, dat1 = '0;
  logic [9:0]  adr0 = '0, adr1 = '0;
  logic        gnt0, gnt1;
  logic        rdFrameDone = 1'b0;
  logic [11:0] outWDAT;
  logic [10:0] outWADR;
  logic        outWREN, bufSwitch, wrPage, ovr;
`ifdef WR_COUNT_EN
  logic [15:0] wrCnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  frame_ram_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .dat0        (dat0),
    .adr0        (adr0),
    .gnt0        (gnt0),
    .req1        (req1),
    .dat1        (dat1),
    .adr1        (adr1),
    .gnt1        (gnt1),
    .rdFrameDone (rdFrameDone),
    .outWDAT     (outWDAT),
    .outWADR     (outWADR),
    .outWREN     (outWREN),
    .bufSwitch   (bufSwitch),
    .wrPage      (wrPage),
`ifdef WR_COUNT_EN
    .wrCnt       (wrCnt),
`endif
    .ovr         (ovr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wren"}, 32'(outWREN), 0);
    chk({tag, "_gnt0"}, 32'(gnt0), 0);
    chk({tag, "_gnt1"}, 32'(gnt1), 0);
  endtask

`ifdef WR_COUNT_EN
  task automatic write0(input logic [9:0] a);
    req0 = 1'b1; adr0 = a; dat0 = 12'h0AA;
    step(); step(); step();
    req0 = 1'b0;
    step();
  endtask
`endif

  logic       exp_w;
  logic [9:0] exp_a;

  initial begin
    // ---- reset state ----
    step(); step();
    chk("rst_wren", 32'(outWREN), 0);
    chk("rst_wadr", 32'(outWADR), 0);
    chk("rst_page", 32'(wrPage), 0);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wren", 32'(outWREN), 0);
    end
    chk_quiet("idle");
    chk("idle_wdat", 32'(outWDAT), 0);
    chk("idle_wadr", 32'(outWADR), 0);
    chk("idle_bsw",  32'(bufSwitch), 0);
    chk("idle_page", 32'(wrPage), 0);
    chk("idle_ovr",  32'(ovr), 0);

    // ---- single write from requester 0 ----
    req0 = 1'b1; dat0 = 12'h5A5; adr0 = 10'h003;
    step();
    chk("w0_wren1", 32'(outWREN), 1);
    chk("w0_wadr",  32'(outWADR), 32'h003);
    chk("w0_wdat",  32'(outWDAT), 32'h5A5);
    chk("w0_gnt_early", 32'(gnt0), 0);
    step();
    chk("w0_wren2", 32'(outWREN), 1);
    chk("w0_gnt_early2", 32'(gnt0), 0);
    step();
    chk("w0_wren_off", 32'(outWREN), 0);
    chk("w0_gnt0", 32'(gnt0), 1);
    chk("w0_gnt1", 32'(gnt1), 0);
    req0 = 1'b0;
    step();
    chk("w0_gnt_pulse", 32'(gnt0), 0);
    step();
    chk_quiet("w0_after");

    // ---- fresh reset so the round-robin pointer starts at 0 ----
    #2 reset = 1'b0;
    #3 reset = 1'b1;

    // ---- both requesters held: grants alternate 0,1,0,1 every 4 cycles ----
    req0 = 1'b1; dat0 = 12'h111; adr0 = 10'h010;
    req1 = 1'b1; dat1 = 12'h222; adr1 = 10'h020;
    for (int i = 0; i < 4; i++) begin
      exp_w = i[0];
      exp_a = exp_w ? 10'h020 : 10'h010;
      step();
      chk("rr_wren1", 32'(outWREN), 1);
      chk("rr_wadr",  32'(outWADR), 32'(exp_a));
      chk("rr_wdat",  32'(outWDAT), exp_w ? 32'h222 : 32'h111);
      step();
      chk("rr_wren2", 32'(outWREN), 1);
      step();
      chk("rr_wren_off", 32'(outWREN), 0);
      chk("rr_gnt0", 32'(gnt0), 32'(!exp_w));
      chk("rr_gnt1", 32'(gnt1), 32'(exp_w));
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
      chk("rr_ack_gnt", 32'(gnt0 | gnt1), 0);
    end
    step();
    chk_quiet("rr_done");

    // ---- swap requested during a requester 1 write (pointer now 0) ----
    req1 = 1'b1; dat1 = 12'h3C3; adr1 = 10'h055;
    step();
    chk("sw_wadr", 32'(outWADR), 32'h055);
    rdFrameDone = 1'b1;
    step();
    rdFrameDone = 1'b0;
    chk("sw_wren2", 32'(outWREN), 1);
    chk("sw_wadr_hold", 32'(outWADR), 32'h055);
    step();
    chk("sw_gnt1", 32'(gnt1), 1);
    chk("sw_page_pre", 32'(wrPage), 0);
    req1 = 1'b0;
    step();                               // ACK
    step();                               // IDLE sees pending swap
    chk("sw_bsw_pre", 32'(bufSwitch), 0);
    step();                               // SWAP cycle
    chk("sw_bsw", 32'(bufSwitch), 1);
    chk("sw_page", 32'(wrPage), 1);
    chk("sw_ovr", 32'(ovr), 0);
    req0 = 1'b1; dat0 = 12'h0AB; adr0 = 10'h3FF;
    step();
    chk("pg1_wren", 32'(outWREN), 1);
    chk("pg1_wadr", 32'(outWADR), 32'h7FF);
    step(); step();
    chk("pg1_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    step();

    // ---- two rdFrameDone pulses during one write: overrun, single swap ----
    req1 = 1'b1; dat1 = 12'h001; adr1 = 10'h001;
    step();
    chk("ov_wadr", 32'(outWADR), 32'h401);
    rdFrameDone = 1'b1;
    step();
    chk("ov_ovr_first", 32'(ovr), 0);
    step();
    rdFrameDone = 1'b0;
    chk("ov_ovr", 32'(ovr), 1);
    chk("ov_gnt1", 32'(gnt1), 1);
    req1 = 1'b0;
    step();                               // ACK
    step();                               // IDLE -> SWAP
    step();                               // SWAP
    chk("ov_page", 32'(wrPage), 0);
    chk("ov_bsw", 32'(bufSwitch), 0);
    step(); step();
    chk("ov_single_page", 32'(wrPage), 0);
    chk("ov_single_bsw", 32'(bufSwitch), 0);
    chk("ov_sticky", 32'(ovr), 1);

    // ---- reset in the middle of a write ----
    req0 = 1'b1; dat0 = 12'hFFF; adr0 = 10'h2AA;
    step();
    chk("ra_wren", 32'(outWREN), 1);
    #2 reset = 1'b0;
    #1;
    chk("ra_wren_async", 32'(outWREN), 0);
    chk("ra_ovr", 32'(ovr), 0);
    chk("ra_wadr", 32'(outWADR), 0);
    req0 = 1'b0;
    #3 reset = 1'b1;
    step(); step(); step();
    chk_quiet("ra_after");

`ifdef WR_COUNT_EN
    // ---- per-page write counter ----
    for (int i = 0; i < 5; i++) write0(10'(i));
    rdFrameDone = 1'b1;
    step();                               // swapPend set
    rdFrameDone = 1'b0;
    step();                               // IDLE -> SWAP
    step();                               // SWAP snapshot
    chk("cnt_five", 32'(wrCnt), 5);
    rdFrameDone = 1'b1;
    step();
    rdFrameDone = 1'b0;
    step(); step();
    chk("cnt_zero", 32'(wrCnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
